// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: widths, reset PC,
// instruction field bounds and fetch FSM state encodings.
package instruction_fetch_pkg;

    localparam int ADDR_W = 16;
    localparam int INST_W = 32;
    localparam logic [15:0] RESET_PC = 16'h0000;

    // Instruction field bounds (consumed by the decoder)
    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 29;
    localparam int REG0_HI = 28;
    localparam int REG0_LO = 24;
    localparam int REG1_HI = 23;
    localparam int REG1_LO = 19;
    localparam int REG2_HI = 18;
    localparam int REG2_LO = 14;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t S_IDLE  = 2'd0;
    localparam fetch_state_t S_FETCH = 2'd1;
    localparam fetch_state_t S_WAIT  = 2'd2;

endpackage

// File: rtl/fetch_ir.sv
// Instruction register with valid/ready handshake.
// Ports: clk, rst; load/load_data/load_pc write a new word; flush drops
// the held word; inst_ready consumes it; inst/inst_pc/inst_valid out.
module fetch_ir #(
    parameter int ADDR_W = 16,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [INST_W-1:0] load_data,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              flush,
    input  logic              inst_ready,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
        end else if (flush) begin
            inst_valid <= 1'b0;
        end else if (load) begin
            // A load wins over a same-cycle consume.
            inst_valid <= 1'b1;
            inst       <= load_data;
            inst_pc    <= load_pc;
        end else if (inst_valid && inst_ready) begin
            inst_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, single-outstanding imem reads, redirect and halt.
// Ports: imem_* memory interface, redirect_*, halt, inst_* downstream
// handshake to the decoder, pc = next fetch address.
module instruction_fetch #(
    parameter int ADDR_W = instruction_fetch_pkg::ADDR_W,
    parameter int INST_W = instruction_fetch_pkg::INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC =
        instruction_fetch_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              halt,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic [ADDR_W-1:0] pc
);

    import instruction_fetch_pkg::*;

    fetch_state_t      state;
    logic [ADDR_W-1:0] pend_pc;
    logic              kill;
    logic              granted;
    logic              load;
    logic              flush;

    assign imem_req = (state == S_FETCH) && !halt
                      && (!inst_valid || inst_ready);
    assign imem_addr = pc;
    assign granted = imem_req && imem_gnt;

    // Redirect drops any response arriving in the same cycle.
    assign load = (state == S_WAIT) && imem_rvalid
                  && !kill && !redirect_valid;
    assign flush = redirect_valid && (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            pend_pc <= RESET_PC;
            kill    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    if (granted) begin
                        state   <= S_WAIT;
                        pend_pc <= pc;
                        // Redirect with grant: the request is in flight
                        // but its response belongs to the old path.
                        kill    <= redirect_valid;
                        pc      <= redirect_valid ? redirect_addr
                                                  : pc + ADDR_W'(1);
                    end else if (redirect_valid) begin
                        pc <= redirect_addr;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) pc <= redirect_addr;
                    if (imem_rvalid) begin
                        state <= S_FETCH;
                        kill  <= 1'b0;
                    end else if (redirect_valid) begin
                        kill <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    fetch_ir #(
        .ADDR_W(ADDR_W),
        .INST_W(INST_W)
    ) u_ir (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (imem_rdata),
        .load_pc    (pend_pc),
        .flush      (flush),
        .inst_ready (inst_ready),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch with a 1-cycle
// instruction memory responder.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        halt;
    logic        inst_valid;
    logic [31:0] inst;
    logic [15:0] inst_pc;
    logic        inst_ready;
    logic [15:0] pc;

    int n_tests = 0;
    int n_fail  = 0;

    instruction_fetch #(
        .ADDR_W(16),
        .INST_W(32),
        .RESET_PC(16'h0010)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .halt           (halt),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .pc             (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return (a == 16'h0010) ? 32'h4A2B_C000 : {16'hC0DE, a};
    endfunction

    // 1-cycle memory, reset together with the fetch unit.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            imem_rvalid <= imem_req && imem_gnt;
            imem_rdata  <= mem_word(imem_addr);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        imem_gnt = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr = '0;
        halt = 1'b0;
        inst_ready = 1'b1;
        repeat (2) tick();
        check_eq("rst_pc", 32'(pc), 32'h0010);
        check_eq("rst_addr", 32'(imem_addr), 32'h0010);
        check_eq("rst_req", 32'(imem_req), 32'h0);
        check_eq("rst_valid", 32'(inst_valid), 32'h0);
        check_eq("rst_inst", inst, 32'h0);
        check_eq("rst_inst_pc", 32'(inst_pc), 32'h0);

        rst = 1'b0;
        check_eq("idle_req", 32'(imem_req), 32'h0);
        tick();
        check_eq("first_req", 32'(imem_req), 32'h1);
        check_eq("first_addr", 32'(imem_addr), 32'h0010);
        tick();
        check_eq("wait_req", 32'(imem_req), 32'h0);
        check_eq("pc_inc", 32'(pc), 32'h0011);
        tick();
        check_eq("i0_valid", 32'(inst_valid), 32'h1);
        check_eq("i0_inst", inst, 32'h4A2B_C000);
        check_eq("i0_pc", 32'(inst_pc), 32'h0010);

        // Downstream stall holds the instruction and blocks fetch
        inst_ready = 1'b0;
        #1;
        check_eq("stall_req0", 32'(imem_req), 32'h0);
        repeat (3) tick();
        check_eq("stall_inst", inst, 32'h4A2B_C000);
        check_eq("stall_valid", 32'(inst_valid), 32'h1);
        check_eq("stall_req", 32'(imem_req), 32'h0);
        inst_ready = 1'b1;
        #1;
        check_eq("unstall_req", 32'(imem_req), 32'h1);
        check_eq("unstall_addr", 32'(imem_addr), 32'h0011);
        repeat (2) tick();
        check_eq("i1_pc", 32'(inst_pc), 32'h0011);
        check_eq("i1_valid", 32'(inst_valid), 32'h1);
        check_eq("i1_next_addr", 32'(imem_addr), 32'h0012);
        repeat (2) tick();
        check_eq("i2_pc", 32'(inst_pc), 32'h0012);
        check_eq("i2_inst", inst, 32'hC0DE_0012);

        // Redirect in WAIT together with rvalid for 0x0013
        tick();
        check_eq("rv_rvalid", 32'(imem_rvalid), 32'h1);
        redirect_valid = 1'b1;
        redirect_addr = 16'h0100;
        tick();
        redirect_valid = 1'b0;
        check_eq("rv_addr", 32'(imem_addr), 32'h0100);
        check_eq("rv_valid", 32'(inst_valid), 32'h0);
        check_eq("rv_req", 32'(imem_req), 32'h1);
        repeat (2) tick();
        check_eq("rv_inst_pc", 32'(inst_pc), 32'h0100);
        check_eq("rv_inst", inst, 32'hC0DE_0100);

        // Redirect in FETCH together with grant for 0x0005
        imem_gnt = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr = 16'h0005;
        tick();
        check_eq("rf_pc5", 32'(pc), 32'h0005);
        imem_gnt = 1'b1;
        redirect_addr = 16'h0200;
        tick();
        redirect_valid = 1'b0;
        check_eq("rf_pc", 32'(pc), 32'h0200);
        check_eq("rf_wait_req", 32'(imem_req), 32'h0);
        tick();
        check_eq("rf_drop", 32'(inst_valid), 32'h0);
        check_eq("rf_req", 32'(imem_req), 32'h1);
        check_eq("rf_addr", 32'(imem_addr), 32'h0200);
        repeat (2) tick();
        check_eq("rf_inst_pc", 32'(inst_pc), 32'h0200);
        check_eq("rf_inst", inst, 32'hC0DE_0200);

        // PC wrap at 0xFFFF
        imem_gnt = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr = 16'hFFFF;
        tick();
        redirect_valid = 1'b0;
        imem_gnt = 1'b1;
        check_eq("wrap_pre", 32'(pc), 32'hFFFF);
        tick();
        check_eq("wrap_pc", 32'(pc), 32'h0000);
        tick();
        check_eq("wrap_inst_pc", 32'(inst_pc), 32'hFFFF);
        check_eq("wrap_inst", inst, 32'hC0DE_FFFF);

        // Halt raised in WAIT: response still lands
        tick();
        halt = 1'b1;
        tick();
        check_eq("halt_valid", 32'(inst_valid), 32'h1);
        check_eq("halt_inst_pc", 32'(inst_pc), 32'h0000);
        check_eq("halt_req", 32'(imem_req), 32'h0);
        tick();
        check_eq("halt_req2", 32'(imem_req), 32'h0);
        check_eq("halt_pc", 32'(pc), 32'h0001);
        redirect_valid = 1'b1;
        redirect_addr = 16'h0300;
        tick();
        redirect_valid = 1'b0;
        check_eq("halt_redir_pc", 32'(pc), 32'h0300);
        check_eq("halt_redir_req", 32'(imem_req), 32'h0);
        halt = 1'b0;
        #1;
        check_eq("unhalt_req", 32'(imem_req), 32'h1);
        check_eq("unhalt_addr", 32'(imem_addr), 32'h0300);
        tick();
        check_eq("mid_wait_req", 32'(imem_req), 32'h0);

        // Asynchronous reset mid-WAIT
        rst = 1'b1;
        #1;
        check_eq("arst_pc", 32'(pc), 32'h0010);
        check_eq("arst_addr", 32'(imem_addr), 32'h0010);
        check_eq("arst_req", 32'(imem_req), 32'h0);
        check_eq("arst_valid", 32'(inst_valid), 32'h0);
        check_eq("arst_inst", inst, 32'h0);
        check_eq("arst_inst_pc", 32'(inst_pc), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("rerun_req", 32'(imem_req), 32'h1);
        check_eq("rerun_addr", 32'(imem_addr), 32'h0010);
        repeat (2) tick();
        check_eq("rerun_inst", inst, 32'h4A2B_C000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
